// File: rtl/osc_sequencer.sv
// ----------------------------------------------------------------------------
// osc_sequencer
//
// Initiator side of the waveshaper start/done handshake for one voice.
//
// On each accepted sample-rate tick the block does four things:
//   1. It presents the voice phase position, period and wave mode to the
//      waveshaper.
//   2. It pulses ws_start for one cycle.
//   3. It waits for ws_done.
//   4. It latches the returned signal and emits it as a one-cycle-valid sample.
//
// The block owns the per-voice phase counter. The counter wraps at the
// latched period. The period and mode are only re-sampled at the period
// boundary (phase 0), so a note change never glitches a waveform mid-cycle.
//
// Optional feature (macro OSC_SEQ_TIMEOUT_EN):
//   When defined, a request that sees no ws_done within TIMEOUT cycles of WAIT
//   is abandoned. On abandon: err pulses, sample_out is held, the phase still
//   advances, and the FSM returns to IDLE. A ws_done arriving in the same
//   cycle as the timeout wins.
//   When undefined, WAIT waits indefinitely and err is tied low.
//
// Parameters:
//   CNT_W     width of phase count / period
//   SAMPLE_W  width of waveshaper result and sample_out
//   TIMEOUT   WAIT cycles before abandoning a request (>= 2, macro build only)
//
// Ports:
//   clk           system clock, rising edge
//   nrst          synchronous active-low reset
//   en            voice enable
//   sample_tick   one-cycle sample-rate strobe
//   fd_in         requested period (ticks per note cycle)
//   mode_in       requested wave mode (00 off, 01 square, 10 tri, 11 saw)
//   ws_count      phase position to waveshaper
//   ws_fd         period to waveshaper
//   ws_mode       wave mode to waveshaper
//   ws_start      one-cycle request pulse
//   ws_done       one-cycle completion from waveshaper
//   ws_signal     waveshaper result, valid with ws_done
//   sample_out    last accepted sample (held)
//   sample_valid  one-cycle pulse when sample_out updates
//   busy          high in any state other than IDLE
//   overrun       one-cycle pulse: tick arrived while busy and was dropped
//   err           one-cycle pulse: request timed out
// ----------------------------------------------------------------------------
module osc_sequencer #(
    parameter int CNT_W    = 18,
    parameter int SAMPLE_W = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic                sample_tick,
    input  logic [CNT_W-1:0]    fd_in,
    input  logic [1:0]          mode_in,
    output logic [CNT_W-1:0]    ws_count,
    output logic [CNT_W-1:0]    ws_fd,
    output logic [1:0]          ws_mode,
    output logic                ws_start,
    input  logic                ws_done,
    input  logic [SAMPLE_W-1:0] ws_signal,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                overrun,
    output logic                err
);

    // Elaboration-time sanity check: the timeout compare needs at least
    // two cycles of WAIT to be meaningful.
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("osc_sequencer: TIMEOUT must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] phase_cnt;

    logic accept;     // tick taken in IDLE
    logic done_take;  // completion accepted in WAIT
    logic tmo_hit;    // request abandoned this cycle

    // Phase advance with wrap at the latched period. The increment is done
    // one bit wider so count+1 can never overflow before the compare; a
    // period of 0 therefore pins the phase at 0.
    function automatic logic [CNT_W-1:0] next_phase(
        input logic [CNT_W-1:0] cur,
        input logic [CNT_W-1:0] period
    );
        logic [CNT_W:0] inc;
        inc = {1'b0, cur} + {{CNT_W{1'b0}}, 1'b1};
        if (inc >= {1'b0, period})
            return '0;
        else
            return inc[CNT_W-1:0];
    endfunction

    assign accept    = en && sample_tick;
    assign done_take = (state == S_WAIT) && ws_done;

`ifdef OSC_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // Done in the same cycle as the timeout takes priority.
    assign tmo_hit = (state == S_WAIT) && !ws_done && (tmo_cnt == TMO_LAST);

    // WAIT cycle counter: cleared outside WAIT so every request starts at 0.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (state == S_WAIT && !tmo_hit && !ws_done)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            else
                tmo_cnt <= '0;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_REQ;
            S_REQ:  state_nxt = S_WAIT;
            S_WAIT: if (done_take || tmo_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ws_start = (state == S_REQ);
    assign busy     = (state != S_IDLE);

    // State register and datapath. ws_count/ws_fd/ws_mode are only written
    // on acceptance in IDLE, so they stay stable from REQ through WAIT.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state        <= S_IDLE;
            phase_cnt    <= '0;
            ws_count     <= '0;
            ws_fd        <= '0;
            ws_mode      <= 2'b00;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nxt;
            sample_valid <= done_take;
            // A tick that lands while a request is in flight is dropped.
            overrun      <= sample_tick && (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // Period/mode only change at the period boundary.
                        if (phase_cnt == '0) begin
                            ws_fd   <= fd_in;
                            ws_mode <= mode_in;
                        end
                        ws_count <= phase_cnt;
                    end else if (!en) begin
                        // Disabled voice restarts phase-aligned on re-enable.
                        phase_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (done_take) begin
                        sample_out <= ws_signal;
                        phase_cnt  <= next_phase(phase_cnt, ws_fd);
                    end else if (tmo_hit) begin
                        // Abandoned request still consumes its phase slot.
                        phase_cnt <= next_phase(phase_cnt, ws_fd);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_osc_sequencer.sv
module tb_osc_sequencer;

    localparam int CNT_W    = 18;
    localparam int SAMPLE_W = 8;
    localparam int TIMEOUT  = 16;

    logic                tb_clk = 1'b0;
    logic                nrst = 1'b0;
    logic                en = 1'b0;
    logic                sample_tick = 1'b0;
    logic [CNT_W-1:0]    fd_in = '0;
    logic [1:0]          mode_in = 2'b00;
    logic [CNT_W-1:0]    ws_count;
    logic [CNT_W-1:0]    ws_fd;
    logic [1:0]          ws_mode;
    logic                ws_start;
    logic                ws_done = 1'b0;
    logic [SAMPLE_W-1:0] ws_signal = '0;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;
    logic                busy;
    logic                overrun;
    logic                err;

    osc_sequencer #(
        .CNT_W    (CNT_W),
        .SAMPLE_W (SAMPLE_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (tb_clk),
        .nrst         (nrst),
        .en           (en),
        .sample_tick  (sample_tick),
        .fd_in        (fd_in),
        .mode_in      (mode_in),
        .ws_count     (ws_count),
        .ws_fd        (ws_fd),
        .ws_mode      (ws_mode),
        .ws_start     (ws_start),
        .ws_done      (ws_done),
        .ws_signal    (ws_signal),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun),
        .err          (err)
    );

    always #5 tb_clk = ~tb_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Waveshaper model: done three cycles after start, signal = count*10.
    logic resp_en = 1'b1;
    initial begin
        logic [CNT_W-1:0] cap;
        forever begin
            @(negedge tb_clk);
            if (ws_start && resp_en) begin
                cap = ws_count;
                repeat (2) @(negedge tb_clk);
                ws_done   = 1'b1;
                ws_signal = SAMPLE_W'(cap * 10);
                @(negedge tb_clk);
                ws_done   = 1'b0;
            end
        end
    end

    // Monitor: counts high cycles of pulses and logs transactions.
    int n_start = 0, n_valid = 0, n_ovr = 0, n_err = 0;
    int cq[$];
    int fq[$];
    int sq[$];
    always @(negedge tb_clk) begin
        if (ws_start) begin
            n_start++;
            cq.push_back(int'(ws_count));
            fq.push_back(int'(ws_fd));
        end
        if (sample_valid) begin
            n_valid++;
            sq.push_back(int'(sample_out));
        end
        if (overrun) n_ovr++;
        if (err) n_err++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        sample_tick = 1'b1;
        @(negedge tb_clk);
        sample_tick = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge tb_clk);
            k++;
        end
        chk("idle_reached", 32'(busy), 0);
        @(negedge tb_clk);
    endtask

    initial begin
        int s0, v0, o0, b, k;

        // 1. Reset and disabled voice
        @(negedge tb_clk);
        nrst = 1'b0;
        repeat (2) @(negedge tb_clk);
        chk("rst_ws_count", 32'(ws_count), 0);
        chk("rst_ws_fd", 32'(ws_fd), 0);
        chk("rst_outs", {26'd0, ws_mode, ws_start, sample_valid, busy, overrun}, 0);
        chk("rst_sample", 32'(sample_out), 0);
        chk("rst_err", 32'(err), 0);
        nrst = 1'b1;
        s0 = n_start;
        for (int i = 0; i < 3; i++) begin
            tick();
            repeat (2) @(negedge tb_clk);
        end
        chk("dis_no_start", 32'(n_start - s0), 0);
        chk("dis_busy", 32'(busy), 0);
        chk("dis_sample", 32'(sample_out), 0);

        // 2. Six requests, fd=4, square
        en = 1'b1;
        fd_in = 18'd4;
        mode_in = 2'b01;
        b = cq.size();
        v0 = n_valid;
        for (int i = 0; i < 6; i++) begin
            tick();
            wait_idle(20);
        end
        chk("t2_valid_pulses", 32'(n_valid - v0), 6);
        begin
            int exp_c[6] = '{0, 1, 2, 3, 0, 1};
            for (int i = 0; i < 6; i++) begin
                chk("t2_ws_count", 32'(cq[b+i]), 32'(exp_c[i]));
                chk("t2_sample", 32'(sq[v0+i]), 32'(exp_c[i] * 10));
            end
        end
        chk("t2_ws_fd", 32'(ws_fd), 4);
        chk("t2_ws_mode", 32'(ws_mode), 1);

        // 3. Tick during WAIT is dropped
        s0 = n_start;
        o0 = n_ovr;
        b = cq.size();
        tick();
        @(negedge tb_clk);
        tick();
        wait_idle(20);
        chk("t3_overrun", 32'(n_ovr - o0), 1);
        chk("t3_one_start", 32'(n_start - s0), 1);
        tick();
        wait_idle(20);
        chk("t3_count_a", 32'(cq[b]), 2);
        chk("t3_count_b", 32'(cq[b+1]), 3);

        // 4. Period change only at boundary
        b = cq.size();
        tick(); wait_idle(20);
        tick(); wait_idle(20);
        fd_in = 18'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            wait_idle(20);
        end
        begin
            int exp_c[7] = '{0, 1, 2, 3, 0, 1, 0};
            int exp_f[7] = '{4, 4, 4, 4, 2, 2, 2};
            for (int i = 0; i < 7; i++) begin
                chk("t4_ws_count", 32'(cq[b+i]), 32'(exp_c[i]));
                chk("t4_ws_fd", 32'(fq[b+i]), 32'(exp_f[i]));
            end
        end
        tick(); wait_idle(20);
        chk("t4_sample10", 32'(sample_out), 10);

        // 5. Silent responder
        resp_en = 1'b0;
        v0 = n_valid;
`ifdef OSC_SEQ_TIMEOUT_EN
        tick();
        k = 0;
        while (!err && k < 100) begin
            @(negedge tb_clk);
            k++;
        end
        chk("t5_err_delay", 32'(k), 17);
        chk("t5_idle", 32'(busy), 0);
        chk("t5_sample_held", 32'(sample_out), 10);
        @(negedge tb_clk);
        chk("t5_err_single", 32'(err), 0);
        chk("t5_err_count", 32'(n_err), 1);
        chk("t5_no_valid", 32'(n_valid - v0), 0);
        resp_en = 1'b1;
        b = cq.size();
        tick();
        wait_idle(20);
        chk("t5_next_count", 32'(cq[b]), 1);
`else
        tick();
        repeat (40) @(negedge tb_clk);
        chk("t5_stuck_busy", 32'(busy), 1);
        chk("t5_err_zero", 32'(n_err), 0);
        chk("t5_no_valid", 32'(n_valid - v0), 0);
        resp_en = 1'b1;
`endif

        // 6. Reset during WAIT, late done ignored
        nrst = 1'b0;
        repeat (2) @(negedge tb_clk);
        nrst = 1'b1;
        tick(); wait_idle(20);
        tick(); wait_idle(20);
        chk("t6_pre_sample", 32'(sample_out), 10);
        v0 = n_valid;
        tick();
        @(negedge tb_clk);
        nrst = 1'b0;
        @(negedge tb_clk);
        nrst = 1'b1;
        chk("t6_busy_after_rst", 32'(busy), 0);
        repeat (3) @(negedge tb_clk);
        chk("t6_no_valid", 32'(n_valid - v0), 0);
        chk("t6_sample_zero", 32'(sample_out), 0);
        chk("t6_still_idle", 32'(busy), 0);
        b = cq.size();
        tick();
        wait_idle(20);
        chk("t6_count_zero", 32'(cq[b]), 0);

        chk("total_overruns", 32'(n_ovr), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
